// File: rtl/fet_segdrv_ctrl.sv
// Gate sequencer for a segmented low-side NMOS switch plus one high-side gate.
// Adds dead-time, staggered low-side turn-on, Ron trim by mask, and a blanked, sticky overcurrent fault.
module fet_segdrv_ctrl #(
  parameter int NSEG    = 4,
  parameter int DT_W    = 4,
  parameter int STAGGER = 2,
  parameter int BLANK   = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [NSEG-1:0] seg_mask,
  input  logic [DT_W-1:0] deadtime,
  input  logic            oc_det,
  input  logic            fault_clr,
  output logic            gate_hs,
  output logic [NSEG-1:0] gate_ls,
  output logic            iso_en,
  output logic            fault,
  output logic [2:0]      state
);

  localparam int BK_W = $clog2(BLANK + 1);
  localparam int SG_W = $clog2(STAGGER + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    DT_HS   = 3'd2,
    HS_ON   = 3'd3,
    DT_LS   = 3'd4,
    LS_RAMP = 3'd5,
    LS_ON   = 3'd6,
    FLT     = 3'd7
  } state_t;

  state_t          st;
  logic [DT_W-1:0] dt_cnt;
  logic [BK_W-1:0] bk_cnt;
  logic [SG_W-1:0] sg_cnt;
  logic [NSEG-1:0] rem;
  logic [NSEG-1:0] first_seg;
  logic [NSEG-1:0] next_seg;

  // A programmed dead-time of zero still gets one full cycle of both gates off.
  function automatic logic [DT_W-1:0] dt_load(input logic [DT_W-1:0] d);
    return (d == '0) ? DT_W'(1) : d;
  endfunction

  function automatic logic [NSEG-1:0] lsb_of(input logic [NSEG-1:0] m);
    return m & (~m + NSEG'(1));
  endfunction

  assign first_seg = lsb_of(seg_mask);
  assign next_seg  = lsb_of(rem);
  assign state     = st;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= IDLE;
      gate_hs <= 1'b0;
      gate_ls <= '0;
      iso_en  <= 1'b0;
      fault   <= 1'b0;
      dt_cnt  <= '0;
      bk_cnt  <= '0;
      sg_cnt  <= '0;
      rem     <= '0;
    end else if (st != FLT && !en) begin
      st      <= IDLE;
      gate_hs <= 1'b0;
      gate_ls <= '0;
      iso_en  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          st     <= ARM;
          iso_en <= 1'b1;
        end
        ARM: begin
          st     <= pwm_in ? DT_HS : DT_LS;
          dt_cnt <= dt_load(deadtime);
        end
        DT_HS: begin
          if (!pwm_in) begin
            st     <= DT_LS;
            dt_cnt <= dt_load(deadtime);
          end else if (dt_cnt <= DT_W'(1)) begin
            st      <= HS_ON;
            gate_hs <= 1'b1;
            bk_cnt  <= BK_W'(BLANK);
          end else begin
            dt_cnt <= dt_cnt - DT_W'(1);
          end
        end
        DT_LS: begin
          if (pwm_in) begin
            st     <= DT_HS;
            dt_cnt <= dt_load(deadtime);
          end else if (dt_cnt <= DT_W'(1)) begin
            // Mask is captured here; later changes wait for the next ramp.
            gate_ls <= first_seg;
            rem     <= seg_mask & ~first_seg;
            sg_cnt  <= SG_W'(STAGGER);
            st      <= ((seg_mask & ~first_seg) == '0) ? LS_ON : LS_RAMP;
          end else begin
            dt_cnt <= dt_cnt - DT_W'(1);
          end
        end
        HS_ON: begin
          if (oc_det && bk_cnt == '0) begin
            st      <= FLT;
            gate_hs <= 1'b0;
            gate_ls <= '0;
            fault   <= 1'b1;
          end else if (!pwm_in) begin
            st      <= DT_LS;
            gate_hs <= 1'b0;
            dt_cnt  <= dt_load(deadtime);
          end else if (bk_cnt != '0) begin
            bk_cnt <= bk_cnt - BK_W'(1);
          end
        end
        LS_RAMP: begin
          if (pwm_in) begin
            st      <= DT_HS;
            gate_ls <= '0;
            dt_cnt  <= dt_load(deadtime);
          end else if (sg_cnt <= SG_W'(1)) begin
            gate_ls <= gate_ls | next_seg;
            rem     <= rem & ~next_seg;
            sg_cnt  <= SG_W'(STAGGER);
            if ((rem & ~next_seg) == '0) st <= LS_ON;
          end else begin
            sg_cnt <= sg_cnt - SG_W'(1);
          end
        end
        LS_ON: begin
          if (pwm_in) begin
            st      <= DT_HS;
            gate_ls <= '0;
            dt_cnt  <= dt_load(deadtime);
          end
        end
        FLT: begin
          // Fault only clears once the comparator itself has gone quiet.
          if (fault_clr && !oc_det) begin
            st     <= IDLE;
            fault  <= 1'b0;
            iso_en <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fet_segdrv_ctrl.sv
// Scoreboard bench for fet_segdrv_ctrl: per-scenario stimulus tables with expected outputs queued per edge.
module tb_fet_segdrv_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       pwm_in;
  logic [3:0] seg_mask;
  logic [3:0] deadtime;
  logic       oc_det;
  logic       fault_clr;
  logic       gate_hs;
  logic [3:0] gate_ls;
  logic       iso_en;
  logic       fault;
  logic [2:0] state;
  logic [9:0] obs;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       en;
    logic       pwm;
    logic       oc;
    logic       clr;
    logic [3:0] mask;
    logic [3:0] dt;
    logic [9:0] exp;
  } step_t;

  step_t      stq[$];
  logic [9:0] sb[$];

  fet_segdrv_ctrl #(.NSEG(4), .DT_W(4), .STAGGER(2), .BLANK(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .pwm_in(pwm_in), .seg_mask(seg_mask),
    .deadtime(deadtime), .oc_det(oc_det), .fault_clr(fault_clr),
    .gate_hs(gate_hs), .gate_ls(gate_ls), .iso_en(iso_en), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {gate_hs, gate_ls, iso_en, fault, state};

  function automatic logic [9:0] ev(input logic hs, input logic [3:0] ls, input logic iso,
                                    input logic flt, input logic [2:0] st);
    return {hs, ls, iso, flt, st};
  endfunction

  task automatic add(input logic a_en, input logic a_pwm, input logic a_oc, input logic a_clr,
                     input logic [3:0] a_mask, input logic [3:0] a_dt, input logic [9:0] a_exp);
    step_t s;
    s.en = a_en; s.pwm = a_pwm; s.oc = a_oc; s.clr = a_clr;
    s.mask = a_mask; s.dt = a_dt; s.exp = a_exp;
    stq.push_back(s);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Safety invariants on every cycle
  always @(negedge clk) begin
    tests++;
    if ((gate_hs & (|gate_ls)) !== 1'b0) begin
      fails++;
      $display("FAIL overlap: gate_hs=%b gate_ls=%b required no overlap", gate_hs, gate_ls);
    end
    tests++;
    if (((gate_hs | (|gate_ls)) & ~iso_en) !== 1'b0) begin
      fails++;
      $display("FAIL iso_gate: gates=%b%b iso_en=%b required iso_en=1 when gated", gate_hs, gate_ls, iso_en);
    end
  end

  task automatic test_reset();
    step_t s; logic [9:0] e; int n = 0;
    rstn = 1'b0; en = 1'b0; pwm_in = 1'b0; seg_mask = '0; deadtime = '0; oc_det = 1'b0; fault_clr = 1'b0;
    cyc(); cyc();
    tests++;
    if (obs !== 10'd0) begin fails++; $display("FAIL reset_state: got %b required %b", obs, 10'd0); end
    rstn = 1'b1;
    add(1, 0, 0, 0, 4'b0111, 4'd1, ev(0, 4'b0000, 1, 0, 3'd1));
    add(1, 0, 0, 0, 4'b0111, 4'd1, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 0, 0, 0, 4'b0111, 4'd1, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 0, 0, 0, 4'b0111, 4'd1, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 0, 0, 0, 4'b0111, 4'd1, ev(0, 4'b0011, 1, 0, 3'd5));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL reset_ramp step %0d: got %b required %b", n, obs, e); end
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if (obs !== 10'd0) begin fails++; $display("FAIL reset_async: got %b required %b", obs, 10'd0); end
    cyc();
    rstn = 1'b1; en = 1'b0;
    cyc();
    tests++;
    if (obs !== ev(0, 4'b0000, 0, 0, 3'd0)) begin
      fails++; $display("FAIL reset_release: got %b required %b", obs, ev(0, 4'b0000, 0, 0, 3'd0));
    end
  endtask

  task automatic test_deadtime();
    step_t s; logic [9:0] e; int n = 0;
    add(1, 1, 0, 0, 4'b1111, 4'd3, ev(0, 4'b0000, 1, 0, 3'd1));
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 4'b1111, 4'd3, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b1111, 4'd3, ev(1, 4'b0000, 1, 0, 3'd3));
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4'b1111, 4'd3, ev(0, 4'b0000, 1, 0, 3'd4));
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 4'b1111, 4'd3, ev(0, 4'b0001, 1, 0, 3'd5));
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 4'b1111, 4'd3, ev(0, 4'b0011, 1, 0, 3'd5));
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 4'b1111, 4'd3, ev(0, 4'b0111, 1, 0, 3'd5));
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 4'b1111, 4'd3, ev(0, 4'b1111, 1, 0, 3'd6));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL deadtime step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  task automatic test_dt_zero();
    step_t s; logic [9:0] e; int n = 0;
    add(1, 1, 0, 0, 4'b0101, 4'd0, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0101, 4'd0, ev(1, 4'b0000, 1, 0, 3'd3));
    add(1, 0, 0, 0, 4'b0101, 4'd0, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 0, 0, 0, 4'b0101, 4'd0, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 0, 0, 0, 4'b0101, 4'd0, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 0, 0, 0, 4'b0101, 4'd0, ev(0, 4'b0101, 1, 0, 3'd6));
    add(1, 0, 0, 0, 4'b1111, 4'd0, ev(0, 4'b0101, 1, 0, 3'd6));
    add(1, 0, 0, 0, 4'b1111, 4'd0, ev(0, 4'b0101, 1, 0, 3'd6));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL dt_zero step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  task automatic test_glitch();
    step_t s; logic [9:0] e; int n = 0;
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(1, 4'b0000, 1, 0, 3'd3));
    add(1, 0, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(1, 4'b0000, 1, 0, 3'd3));
    add(1, 0, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 0, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 0, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd2, ev(1, 4'b0000, 1, 0, 3'd3));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL pwm_glitch step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  task automatic test_oc_blank();
    step_t s; logic [9:0] e; int n = 0;
    for (int c = 1; c <= 8; c++)
      add(1, 1, ((c >= 2 && c <= 5) || c == 8), 0, 4'b0011, 4'd2, ev(1, 4'b0000, 1, 0, 3'd3));
    add(1, 1, 1, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 1, 3'd7));
    add(1, 1, 1, 1, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 1, 3'd7));
    add(0, 1, 1, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 1, 1, 3'd7));
    add(0, 0, 0, 1, 4'b0011, 4'd2, ev(0, 4'b0000, 0, 0, 3'd0));
    add(0, 0, 0, 0, 4'b0011, 4'd2, ev(0, 4'b0000, 0, 0, 3'd0));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL oc_blank step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  task automatic test_en_drop();
    step_t s; logic [9:0] e; int n = 0;
    add(1, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0000, 1, 0, 3'd1));
    add(1, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0001, 1, 0, 3'd5));
    add(1, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0011, 1, 0, 3'd6));
    add(1, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0011, 1, 0, 3'd6));
    add(0, 0, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0000, 0, 0, 3'd0));
    add(1, 1, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0000, 1, 0, 3'd1));
    add(1, 1, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b0011, 4'd1, ev(1, 4'b0000, 1, 0, 3'd3));
    add(0, 1, 0, 0, 4'b0011, 4'd1, ev(0, 4'b0000, 0, 0, 3'd0));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL en_drop step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  task automatic test_zero_mask();
    step_t s; logic [9:0] e; int n = 0;
    add(1, 0, 0, 0, 4'b0000, 4'd1, ev(0, 4'b0000, 1, 0, 3'd1));
    add(1, 0, 0, 0, 4'b0000, 4'd1, ev(0, 4'b0000, 1, 0, 3'd4));
    add(1, 0, 0, 0, 4'b0000, 4'd1, ev(0, 4'b0000, 1, 0, 3'd6));
    add(1, 0, 0, 0, 4'b0000, 4'd1, ev(0, 4'b0000, 1, 0, 3'd6));
    add(1, 1, 0, 0, 4'b0000, 4'd1, ev(0, 4'b0000, 1, 0, 3'd2));
    add(0, 1, 0, 0, 4'b0000, 4'd1, ev(0, 4'b0000, 0, 0, 3'd0));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL zero_mask step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  task automatic test_dt_max();
    step_t s; logic [9:0] e; int n = 0;
    add(1, 1, 0, 0, 4'b1111, 4'd15, ev(0, 4'b0000, 1, 0, 3'd1));
    for (int i = 0; i < 15; i++) add(1, 1, 0, 0, 4'b1111, 4'd15, ev(0, 4'b0000, 1, 0, 3'd2));
    add(1, 1, 0, 0, 4'b1111, 4'd15, ev(1, 4'b0000, 1, 0, 3'd3));
    add(0, 1, 0, 0, 4'b1111, 4'd15, ev(0, 4'b0000, 0, 0, 3'd0));
    while (stq.size() != 0) begin
      s = stq.pop_front();
      en = s.en; pwm_in = s.pwm; oc_det = s.oc; fault_clr = s.clr; seg_mask = s.mask; deadtime = s.dt;
      sb.push_back(s.exp);
      cyc();
      e = sb.pop_front(); n++; tests++;
      if (obs !== e) begin fails++; $display("FAIL dt_max step %0d: got %b required %b", n, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_deadtime();
    test_dt_zero();
    test_glitch();
    test_oc_blank();
    test_en_drop();
    test_zero_mask();
    test_dt_max();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
